alu_arbiter: RTL and testbench

- Shares one 32-bit ALU datapath among NUM_REQ independent requesters, e.g. decode-stage address calc, branch compare and a debug port.
- Arbitration is round-robin with a valid/ready handshake per requester.
- Each accepted operation goes through a combinational ALU and is captured in a one-deep registered response slot, tagged with the requester ID.
- Sits between the requester units and the response consumer. The consumer applies backpressure through rsp_ready.

---
 rtl/alu_arbiter.sv | 98 +++++++++
 tb/tb_alu_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU among NUM_REQ requesters; each accepted
// op is captured in a one-deep registered response slot tagged with the requester ID.
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]  req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_result,
    output logic                  rsp_zero
);

    // Handshake: a transfer occurs on a rising edge where valid and ready are both high.
    // valid never waits on ready, and the sender holds its payload stable until that edge.

    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] win;
    logic            found;
    logic            can_accept;
    logic            accept;
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic [2:0]      sel_op;
    logic [31:0]     alu_res;

    assign can_accept = !rsp_valid || rsp_ready;
    assign accept     = found && can_accept && !reset;

    // Priority starts just after the last winner and wraps; nearest offset wins.
    always_comb begin
        win   = last_grant;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req_valid[i] && (i == (int'(last_grant) + k) % NUM_REQ)) begin
                    found = 1'b1;
                    win   = ID_W'(i);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_op    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == ID_W'(i)) begin
                req_ready[i] = accept;
                sel_a        = req_a[32*i +: 32];
                sel_b        = req_b[32*i +: 32];
                sel_op       = req_op[3*i +: 3];
            end
        end
    end

    // Unused encodings resolve to zero so no X can reach the slot.
    always_comb begin
        alu_res = '0;
        case (sel_op)
            3'b000:  alu_res = sel_a + sel_b;
            3'b001:  alu_res = sel_a - sel_b;
            3'b010:  alu_res = sel_a & sel_b;
            3'b011:  alu_res = sel_a | sel_b;
            3'b101:  alu_res = {31'd0, ($signed(sel_a) < $signed(sel_b))};
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else if (accept) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= win;
            rsp_result <= alu_res;
            rsp_zero   <= (alu_res == 32'd0);
            last_grant <= win;
        end else if (rsp_ready) begin
            // Drain only clears the flag; data fields keep their last value.
            rsp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a queue-based reference model checks every cycle,
// while directed scenarios pin literal expectations.
module tb_alu_arbiter;

    localparam int N    = 4;
    localparam int ID_W = 2;
    localparam int W    = ID_W + 33;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N*3-1:0]  req_op;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [ID_W-1:0] rsp_id;
    logic [31:0]     rsp_result;
    logic            rsp_zero;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    int           m_last;
    bit           model_on = 1'b0;
    logic [N-1:0] acc_vec  = '0;

    alu_arbiter #(.NUM_REQ(N), .ID_W(ID_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // scoreboard: the one-deep slot is the head of exp_q
    always @(negedge clk) begin
        int           win;
        int           best;
        int           d;
        logic [N-1:0] exp_ready;
        logic [31:0]  r;
        if (reset) begin
            chk("ready_in_reset", 64'(req_ready), 64'd0);
            exp_q.delete();
            m_last   = N - 1;
            model_on = 1'b1;
            acc_vec  = '0;
        end else if (model_on) begin
            win  = -1;
            best = N + 1;
            for (int i = 0; i < N; i++) begin
                d = (i - m_last - 1 + 2 * N) % N;
                if (req_valid[i] && d < best) begin
                    best = d;
                    win  = i;
                end
            end
            exp_ready = '0;
            if (win >= 0 && (exp_q.size() == 0 || rsp_ready)) exp_ready[win] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0)
                chk("rsp_slot", 64'({rsp_id, rsp_result, rsp_zero}), 64'(exp_q[0]));
            if (exp_q.size() != 0 && rsp_ready) void'(exp_q.pop_front());
            acc_vec = exp_ready & req_valid;
            if (exp_ready != '0) begin
                r = alu_ref(req_a[32*win +: 32], req_b[32*win +: 32], req_op[3*win +: 3]);
                exp_q.push_back({ID_W'(win), r, (r == 32'd0)});
                m_last = win;
            end
        end
    end

    // driver tasks (all start and end 1 time unit after a rising edge)
    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
        req_valid[i]      = 1'b1;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_op[3*i +: 3]  = op;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
        bit ok = 1'b0;
        set_req(i, a, b, op);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL issue_timeout: act=no_accept exp=accept req=%0d", i);
        end
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic single(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [31:0] exp_r, input logic exp_z);
        rsp_ready = 1'b1;
        issue(1, a, b, op);
        @(negedge clk);
        chk({name, "_valid"}, 64'(rsp_valid), 64'd1);
        chk({name, "_id"}, 64'(rsp_id), 64'd1);
        chk({name, "_result"}, 64'(rsp_result), 64'(exp_r));
        chk({name, "_zero"}, 64'(rsp_zero), 64'(exp_z));
        @(posedge clk); #1;
    endtask

    initial begin
        int order[6] = '{0, 1, 2, 3, 0, 1};
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_valid", 64'(rsp_valid), 64'd0);
        chk("reset_id", 64'(rsp_id), 64'd0);
        chk("reset_result", 64'(rsp_result), 64'd0);
        chk("reset_zero", 64'(rsp_zero), 64'd0);
        @(posedge clk); #1;

        // only requester 2
        set_req(2, 32'd5, 32'd7, 3'b000);
        @(negedge clk);
        chk("t1_ready", 64'(req_ready), 64'b0100);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        @(negedge clk);
        chk("t1_valid", 64'(rsp_valid), 64'd1);
        chk("t1_id", 64'(rsp_id), 64'd2);
        chk("t1_result", 64'(rsp_result), 64'd12);
        chk("t1_zero", 64'(rsp_zero), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_drained", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;

        // all four continuously valid: results 101..104
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 32'(i + 1), 32'd100, 3'b000);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rr_ready", 64'(req_ready), 64'(1 << order[k]));
            if (k > 0) begin
                chk("rr_id", 64'(rsp_id), 64'(order[k-1]));
                chk("rr_result", 64'(rsp_result), 64'(101 + order[k-1]));
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
        @(negedge clk);
        chk("rr_last_id", 64'(rsp_id), 64'd1);
        chk("rr_last_result", 64'(rsp_result), 64'd102);
        @(posedge clk); #1;

        // ALU op corners on requester 1
        single("sub_zero", 32'd3, 32'd3, 3'b001, 32'd0, 1'b1);
        single("slt_neg", 32'hFFFF_FFFF, 32'd1, 3'b101, 32'd1, 1'b0);
        single("slt_pos", 32'd1, 32'hFFFF_FFFF, 3'b101, 32'd0, 1'b1);
        single("slt_small", 32'd5, 32'd7, 3'b101, 32'd1, 1'b0);
        single("op111", 32'd9, 32'd4, 3'b111, 32'd0, 1'b1);
        single("op100", 32'd5, 32'd5, 3'b100, 32'd0, 1'b1);
        single("op110", 32'd1, 32'd2, 3'b110, 32'd0, 1'b1);
        single("and", 32'h0000_F0F0, 32'h0000_FF00, 3'b010, 32'h0000_F000, 1'b0);
        single("or", 32'h0000_F0F0, 32'h0000_FF00, 3'b011, 32'h0000_FFF0, 1'b0);
        single("add_wrap", 32'hFFFF_FFFF, 32'd2, 3'b000, 32'd1, 1'b0);
        single("sub_wrap", 32'd0, 32'd1, 3'b001, 32'hFFFF_FFFF, 1'b0);

        // backpressure with requesters 0 and 3
        do_reset();
        rsp_ready = 1'b0;
        set_req(0, 32'd1, 32'd2, 3'b000);
        set_req(3, 32'd9, 32'd4, 3'b001);
        @(negedge clk);
        chk("bp_first_ready", 64'(req_ready), 64'b0001);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_stall_ready", 64'(req_ready), 64'd0);
            chk("bp_stall_valid", 64'(rsp_valid), 64'd1);
            chk("bp_stall_id", 64'(rsp_id), 64'd0);
            chk("bp_stall_result", 64'(rsp_result), 64'd3);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(req_ready), 64'b1000);
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        @(negedge clk);
        chk("bp_r3_valid", 64'(rsp_valid), 64'd1);
        chk("bp_r3_id", 64'(rsp_id), 64'd3);
        chk("bp_r3_result", 64'(rsp_result), 64'd5);
        @(posedge clk); #1;

        // reset while the slot holds a response from requester 2
        do_reset();
        rsp_ready = 1'b0;
        issue(2, 32'd8, 32'd8, 3'b010);
        @(negedge clk);
        chk("mr_held_valid", 64'(rsp_valid), 64'd1);
        chk("mr_held_id", 64'(rsp_id), 64'd2);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 32'(i), 32'd1, 3'b000);
        @(negedge clk);
        chk("mr_ready_in_reset", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        reset     = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("mr_valid_cleared", 64'(rsp_valid), 64'd0);
        chk("mr_first_grant", 64'(req_ready), 64'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        @(posedge clk); #1;

        // mixed traffic with random backpressure, checked by the scoreboard
        for (int c = 0; c < 80; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || acc_vec[i]) begin
                    if ($urandom_range(0, 2) != 0)
                        set_req(i,
                                ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom,
                                ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom,
                                3'($urandom_range(0, 7)));
                    else
                        req_valid[i] = 1'b0;
                end
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("final_idle_valid", 64'(rsp_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
